// File: rtl/gc_out_arbiter.sv
// Output arbiter for N garbler cores: round-robin grant with burst lock on
// garbled-table words (tag 010), feeding one registered valid/ready stage.
`timescale 1ns/1ps
module gc_out_arbiter #(
  parameter int N         = 4,
  parameter int S         = 20,
  parameter int K         = 128,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3*N-1:0]       req_tag,
  input  logic [S*N-1:0]       req_cid,
  input  logic [S*N-1:0]       req_index0,
  input  logic [S*N-1:0]       req_index1,
  input  logic [K*N-1:0]       req_data0,
  input  logic [K*N-1:0]       req_data1,
  output logic [N-1:0]         req_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_src,
  output logic [2:0]           out_tag,
  output logic [S-1:0]         out_cid,
  output logic [S-1:0]         out_index0,
  output logic [S-1:0]         out_index1,
  output logic [K-1:0]         out_data0,
  output logic [K-1:0]         out_data1
);
  localparam int         W      = $clog2(N);
  localparam logic [2:0] TAG_GT = 3'b010;
  localparam logic [7:0] CAP    = 8'(MAX_BURST);

  typedef enum logic [0:0] {ARB = 1'b0, BURST = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] rr_ptr, rr_nxt, owner, owner_nxt, rr_pick, gnt;
  logic [7:0]   burst_cnt, cnt_nxt;
  logic [N-1:0] req;
  logic         pick_vld, gnt_vld, ld, consume;
  logic [2:0]   gnt_tag;

  // Explicit wrap so non-power-of-two N never relies on overflow.
  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] p);
    if (p == W'(N-1)) begin
      return {W{1'b0}};
    end else begin
      return p + W'(1);
    end
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i] = |req_tag[3*i +: 3];
    end
  end

  // Descending scan so the requester closest to rr_ptr wins last.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    rr_pick  = rr_ptr;
    for (int k = N-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (req[idx]) begin
        pick_vld = 1'b1;
        rr_pick  = W'(idx);
      end else begin
        pick_vld = pick_vld;
      end
    end
  end

  always_comb begin
    if (state == BURST) begin
      gnt     = owner;
      gnt_vld = req[owner];
    end else begin
      gnt     = rr_pick;
      gnt_vld = pick_vld;
    end
    gnt_tag   = req_tag[3*int'(gnt) +: 3];
    ld        = ~out_valid | out_ready;
    consume   = ld & gnt_vld;
    req_ready = (rst_n && consume) ? ({{(N-1){1'b0}}, 1'b1} << gnt) : {N{1'b0}};
  end

  // Next-state logic for arbitration pointer, burst owner and burst count.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    cnt_nxt   = burst_cnt;
    case (state)
      ARB: begin
        if (consume) begin
          rr_nxt = wrap_inc(gnt);
          if ((gnt_tag == TAG_GT) && (MAX_BURST > 1)) begin
            state_nxt = BURST;
            owner_nxt = gnt;
            cnt_nxt   = 8'd1;
          end else begin
            state_nxt = ARB;
          end
        end else begin
          state_nxt = ARB;
        end
      end
      BURST: begin
        if (!gnt_vld) begin
          // Owner went idle: release without consuming anything.
          state_nxt = ARB;
          cnt_nxt   = 8'd0;
        end else if (consume) begin
          if ((gnt_tag == TAG_GT) && ((burst_cnt + 8'd1) < CAP)) begin
            cnt_nxt = burst_cnt + 8'd1;
          end else begin
            state_nxt = ARB;
            cnt_nxt   = 8'd0;
            rr_nxt    = wrap_inc(owner);
          end
        end else begin
          state_nxt = BURST;
        end
      end
      default: begin
        state_nxt = ARB;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      rr_ptr    <= {W{1'b0}};
      owner     <= {W{1'b0}};
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  // Output stage: load on consume, otherwise hold fields and drop valid once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_src    <= {W{1'b0}};
      out_tag    <= 3'b000;
      out_cid    <= {S{1'b0}};
      out_index0 <= {S{1'b0}};
      out_index1 <= {S{1'b0}};
      out_data0  <= {K{1'b0}};
      out_data1  <= {K{1'b0}};
    end else if (consume) begin
      out_valid  <= 1'b1;
      out_src    <= gnt;
      out_tag    <= gnt_tag;
      out_cid    <= req_cid[S*int'(gnt) +: S];
      out_index0 <= req_index0[S*int'(gnt) +: S];
      out_index1 <= req_index1[S*int'(gnt) +: S];
      out_data0  <= req_data0[K*int'(gnt) +: K];
      out_data1  <= req_data1[K*int'(gnt) +: K];
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end else begin
      out_valid  <= out_valid;
    end
  end

endmodule

// File: tb/tb_gc_out_arbiter.sv
// Bench for gc_out_arbiter: per-core word queues feed the DUT; a transaction-level
// model of the grant rules predicts req_ready and the output word every cycle.
`timescale 1ns/1ps
module tb_gc_out_arbiter;
  localparam int N  = 4;
  localparam int S  = 20;
  localparam int K  = 128;
  localparam int MB = 16;

  typedef struct packed {
    logic [2:0]   tag;
    logic [S-1:0] cid;
    logic [S-1:0] i0;
    logic [S-1:0] i1;
    logic [K-1:0] d0;
    logic [K-1:0] d1;
  } word_t;

  logic           clk, rst_n, out_ready, out_valid;
  logic [3*N-1:0] req_tag;
  logic [S*N-1:0] req_cid, req_index0, req_index1;
  logic [K*N-1:0] req_data0, req_data1;
  logic [N-1:0]   req_ready;
  logic [1:0]     out_src;
  logic [2:0]     out_tag;
  logic [S-1:0]   out_cid, out_index0, out_index1;
  logic [K-1:0]   out_data0, out_data1;

  gc_out_arbiter #(.N(N), .S(S), .K(K), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_tag(req_tag), .req_cid(req_cid),
    .req_index0(req_index0), .req_index1(req_index1), .req_data0(req_data0),
    .req_data1(req_data1), .req_ready(req_ready), .out_ready(out_ready),
    .out_valid(out_valid), .out_src(out_src), .out_tag(out_tag), .out_cid(out_cid),
    .out_index0(out_index0), .out_index1(out_index1), .out_data0(out_data0),
    .out_data1(out_data1)
  );

  always #5 clk = ~clk;

  // Source side: a queued item with tag 000 is a one-cycle idle gap.
  word_t src_q [N][$];
  word_t cur   [N];
  int    log_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Model: which core holds the link (-1 none), its run length, and who has priority.
  bit    m_valid;
  word_t m_word;
  int    m_src, m_lock, m_streak, m_pref;

  function automatic word_t mk(input logic [2:0] tag);
    word_t w;
    w.tag = tag;
    w.cid = S'($urandom);
    w.i0  = S'($urandom);
    w.i1  = S'($urandom);
    w.d0  = {$urandom, $urandom, $urandom, $urandom};
    w.d1  = {$urandom, $urandom, $urandom, $urandom};
    return w;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_word = '0; m_src = 0; m_lock = -1; m_streak = 0; m_pref = 0;
  endtask

  task automatic flush_queues();
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      cur[i] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      req_tag[3*i +: 3]    = cur[i].tag;
      req_cid[S*i +: S]    = cur[i].cid;
      req_index0[S*i +: S] = cur[i].i0;
      req_index1[S*i +: S] = cur[i].i1;
      req_data0[K*i +: K]  = cur[i].d0;
      req_data1[K*i +: K]  = cur[i].d1;
    end
  endtask

  // Drive one cycle's inputs, predict the grant, score req_ready, advance the model.
  task automatic tick_model(input bit rdy);
    int g;
    bit ld, take;
    logic [N-1:0] exp_rr;
    drive_inputs();
    out_ready = rdy;
    #1;
    if (out_valid && out_ready) log_q.push_back(int'(out_src));
    ld = !m_valid || rdy;
    g  = -1;
    if (m_lock >= 0) begin
      if (cur[m_lock].tag != 3'b000) g = m_lock;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && cur[(m_pref + k) % N].tag != 3'b000) g = (m_pref + k) % N;
      end
    end
    take   = ld && (g >= 0);
    exp_rr = '0;
    if (take) exp_rr[g] = 1'b1;
    n_checks++;
    if (req_ready !== exp_rr) begin
      n_fail++;
      $display("FAIL req_ready at %0t: got %b want %b", $time, req_ready, exp_rr);
    end
    if (m_lock >= 0) begin
      if (cur[m_lock].tag == 3'b000) m_lock = -1;
      else if (take) begin
        if (cur[g].tag == 3'b010 && m_streak + 1 < MB) m_streak++;
        else begin m_lock = -1; m_pref = (g + 1) % N; end
      end
    end else if (take) begin
      m_pref = (g + 1) % N;
      if (cur[g].tag == 3'b010 && MB > 1) begin m_lock = g; m_streak = 1; end
    end
    if (take) begin m_valid = 1'b1; m_src = g; m_word = cur[g]; end
    else if (rdy) m_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && (src_q[i][0].tag == 3'b000 || (take && i == g)))
        void'(src_q[i].pop_front());
    end
  endtask

  task automatic cycle(input bit rdy);
    @(negedge clk);
    n_checks++;
    if (out_valid !== m_valid || int'(out_src) != m_src ||
        {out_tag, out_cid, out_index0, out_index1, out_data0, out_data1} !== m_word) begin
      n_fail++;
      $display("FAIL out_word at %0t: got v=%b src=%0d tag=%b cid=%h d0=%h want v=%b src=%0d tag=%b cid=%h d0=%h",
               $time, out_valid, out_src, out_tag, out_cid, out_data0,
               m_valid, m_src, m_word.tag, m_word.cid, m_word.d0);
    end
    tick_model(rdy);
  endtask

  task automatic do_reset();
    flush_queues();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    drive_inputs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    flush_queues();
    for (int i = 0; i < N; i++) repeat (2) src_q[i].push_back(mk(3'b101));
    repeat (2) begin
      @(negedge clk);
      drive_inputs();
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || req_ready !== '0 || out_data0 !== '0) begin
        n_fail++;
        $display("FAIL reset_state: got v=%b rr=%b d0=%h want v=0 rr=0 d0=0", out_valid, req_ready, out_data0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick_model(1'b1);
    cycle(1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_first_word: got v=%b src=%0d want v=1 src=0", out_valid, out_src);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) repeat (5) src_q[i].push_back(mk(3'b001));
    log_q.delete();
    repeat (8) cycle(1'b1);
    n_checks++;
    if (log_q.size() != 7) begin
      n_fail++;
      $display("FAIL rr_throughput: got %0d words want 7", log_q.size());
    end
    for (int k = 0; k < 5 && k < log_q.size(); k++) begin
      n_checks++;
      if (log_q[k] != exp_seq[k]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got src %0d want %0d", k, log_q[k], exp_seq[k]);
      end
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    repeat (20) src_q[2].push_back(mk(3'b010));
    src_q[0].push_back(mk(3'b000));
    src_q[0].push_back(mk(3'b011));
    log_q.delete();
    repeat (30) cycle(1'b1);
    n_checks++;
    if (log_q.size() != 21) begin
      n_fail++;
      $display("FAIL burst_count: got %0d words want 21", log_q.size());
    end
    for (int k = 0; k < 21 && k < log_q.size(); k++) begin
      n_checks++;
      if (log_q[k] != ((k == 16) ? 0 : 2)) begin
        n_fail++;
        $display("FAIL burst_order[%0d]: got src %0d want %0d", k, log_q[k], (k == 16) ? 0 : 2);
      end
    end
  endtask

  task automatic test_burst_end();
    do_reset();
    repeat (3) src_q[1].push_back(mk(3'b010));
    src_q[1].push_back(mk(3'b000));
    src_q[3].push_back(mk(3'b001));
    log_q.delete();
    repeat (6) cycle(1'b1);
    n_checks++;
    if (log_q.size() != 4 || log_q[0] != 1 || log_q[1] != 1 || log_q[2] != 1 || log_q[3] != 3) begin
      n_fail++;
      $display("FAIL burst_end: got %0d words last src %0d want 4 words 1,1,1,3",
               log_q.size(), (log_q.size() > 0) ? log_q[log_q.size()-1] : -1);
    end
  endtask

  task automatic test_backpressure();
    logic [K-1:0] snap_d0;
    logic [1:0]   snap_src;
    do_reset();
    for (int i = 0; i < 2; i++) repeat (6) src_q[i].push_back(mk((i == 0) ? 3'b001 : 3'b100));
    log_q.delete();
    repeat (2) cycle(1'b1);
    cycle(1'b0);
    snap_d0 = out_data0; snap_src = out_src;
    repeat (4) begin
      cycle(1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data0 !== snap_d0 || out_src !== snap_src || req_ready !== '0) begin
        n_fail++;
        $display("FAIL backpressure_hold: got v=%b src=%0d rr=%b want v=1 src=%0d rr=0", out_valid, out_src, req_ready, snap_src);
      end
    end
    cycle(1'b1);
    cycle(1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data0 === snap_d0) begin
      n_fail++;
      $display("FAIL backpressure_release: got v=%b want v=1 with new word", out_valid);
    end
    repeat (20) cycle(1'b1);
    n_checks++;
    if (log_q.size() != 12) begin
      n_fail++;
      $display("FAIL backpressure_lost: got %0d words want 12", log_q.size());
    end
  endtask

  task automatic test_async_reset_mid_burst();
    do_reset();
    repeat (10) src_q[2].push_back(mk(3'b010));
    repeat (4) cycle(1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || req_ready !== '0 || out_tag !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b rr=%b tag=%b want 0", out_valid, req_ready, out_tag);
    end
    flush_queues();
    model_reset();
    for (int i = 0; i < N; i++) repeat (2) src_q[i].push_back(mk(3'b001));
    @(negedge clk);
    rst_n = 1'b1;
    tick_model(1'b1);
    cycle(1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL async_restart: got v=%b src=%0d want v=1 src=0", out_valid, out_src);
    end
    repeat (10) cycle(1'b1);
  endtask

  task automatic test_random();
    int left;
    do_reset();
    for (int i = 0; i < N; i++) begin
      repeat (30) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) src_q[i].push_back(mk(3'b010));
        else src_q[i].push_back(mk(3'($urandom_range(0, 7))));
      end
    end
    repeat (500) cycle($urandom_range(0, 3) != 0);
    repeat (60) cycle(1'b1);
    left = 0;
    for (int i = 0; i < N; i++) left += src_q[i].size();
    n_checks++;
    if (left != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d words left v=%b want 0 left v=0", left, out_valid);
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; out_ready = 1'b0;
    req_tag = '0; req_cid = '0; req_index0 = '0; req_index1 = '0; req_data0 = '0; req_data1 = '0;
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_burst_end();
    test_backpressure();
    test_async_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gc_out_arbiter.md
Name: gc_out_arbiter

Overview:
- Merges the tag/index/data output streams of N garbler cores into one shared host link.
- Each core presents one transfer word per cycle: tag, cid, index0/1 and data0/1. Tag 000 means no transfer.
- The arbiter grants cores round-robin and keeps the grant on one core during garbled-table bursts (tag 010), up to a cap.
- It drives a single registered output stage with a valid/ready handshake and applies per-core backpressure through req_ready.

Parameters:
N, 4, number of garbler cores (2..16)
S, 20, index/cid width
K, 128, label/data width
MAX_BURST, 16, maximum consecutive tag-010 words granted to one core before rotation (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
req_tag  in  3*N  per-core tag; core i at [3i+2:3i]; nonzero = request
req_cid  in  S*N  per-core cycle id
req_index0  in  S*N  per-core index0
req_index1  in  S*N  per-core index1
req_data0  in  K*N  per-core data0
req_data1  in  K*N  per-core data1
req_ready  out  N  one-hot; word of core i consumed this cycle
out_ready  in  1  downstream accepts out word
out_valid  out  1  out word valid
out_src  out  $clog2(N)  core index of out word
out_tag  out  3  forwarded tag
out_cid  out  S  forwarded cid
out_index0  out  S  forwarded index0
out_index1  out  S  forwarded index1
out_data0  out  K  forwarded data0
out_data1  out  K  forwarded data1

Behaviour:
- Reset (rst_n=0, async): out_valid=0, all out_* fields=0, req_ready=0, rr pointer=0, burst count=0, state=ARB. Reset mid-transfer drops the held word.
- Load condition: ld = ~out_valid | out_ready. A word is captured only when ld=1 and a grant exists.
- req_ready is combinational: exactly the granted bit when ld=1 and the grant targets a requesting core; otherwise all zero. A word is consumed iff its req_ready bit is 1.
- Latency: a word consumed at cycle t appears at the output at t+1. Sustained throughput is 1 word/cycle while out_ready=1.
- While out_valid=1 and out_ready=0, all out_* fields hold stable.
- States:
  - ARB:
    - Grant the first requesting core at or after rr pointer, in ascending index with wrap N-1 to 0.
    - On consume, rr pointer = granted+1 mod N.
    - If the consumed tag=010, set burst owner=granted, burst count=1, and go to BURST (if MAX_BURST>1).
  - BURST:
    - Grant is fixed to the owner.
    - Owner presents 010 and ld=1: consume and increment burst count.
    - Owner presents a non-010 nonzero tag: consume it and return to ARB.
    - Owner presents tag 000: return to ARB with no consume that cycle. Another core may be granted from the next cycle.
    - Burst count reaching MAX_BURST on a consume: return to ARB. rr pointer = owner+1, so the owner loses priority.
    - ld=0 in BURST: stay, burst count unchanged.
- No requests in ARB: no grant, rr pointer unchanged, and out_valid falls to 0 once the held word is accepted.
- Simultaneous out_ready and a new grant: the old word leaves and the new word loads in the same edge. There is no bubble.
- Words of one core are never reordered. Words of different cores interleave only at grant boundaries.
- Arithmetic: burst count is 8-bit and saturates at MAX_BURST. rr pointer wraps modulo N; for non-power-of-two N it wraps explicitly, never by overflow.

Test Plan:
- Reset: rst_n low with all tags 101 -> out_valid=0, req_ready=0, out_data0=0. Release -> core 0 word out one cycle later, out_src=0.
- Round-robin: N=4, all cores hold tag 001, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
- Burst lock: core 2 streams 20 words of tag 010 while core 0 holds 011, MAX_BURST=16 -> 16 core-2 words, then one core-0 word, then core 2 resumes.
- Burst end: core 1 sends 3 words of 010 then tag 000 while core 3 requests -> out_src 1,1,1 then 3 with no stall beyond one cycle.
- Backpressure: out_ready low for 5 cycles with out_valid=1 -> out_* fields stable, req_ready=0, no words lost. Release -> next word follows on the next cycle.
- Async reset mid-burst: rst_n pulsed during BURST -> out_valid=0 immediately. After release, arbitration restarts from core 0.
